// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between execute and write-back.
// Holds the execute payload, captures SRAM read data, aligns loads and exports stall/forward status.
`default_nettype none

package mem_stage_pkg;
    localparam int ES_TO_MS_BUS_WD = 96;
    localparam int MS_TO_WS_BUS_WD = 86;
    localparam int STALL_BUS_WD    = 10;
    localparam int FORWARD_BUS_WD  = 33;
endpackage

module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic [31:0]                data_sram_rdata,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [STALL_BUS_WD-1:0]    stall_ms_bus,
    output logic [FORWARD_BUS_WD-1:0]  forward_ms_bus,
    output logic [1:0]                 ms_exc_eret_bus
);

    logic                       ms_valid_q,   ms_valid_d;
    logic                       rdata_held_q, rdata_held_d;
    logic [31:0]                rdata_buf_q,  rdata_buf_d;
    logic [ES_TO_MS_BUS_WD-1:0] bus_q,        bus_d;

    logic        w_bd;
    logic        w_exc_sys;
    logic        w_eret_flush;
    logic        w_cp0_wen;
    logic        w_res_from_cp0;
    logic [7:0]  w_cp0_addr;
    logic [6:0]  w_inst_load;
    logic        w_gr_we;
    logic [4:0]  w_dest;
    logic [31:0] w_alu_result;
    logic [31:0] w_pc;
    logic [1:0]  w_addr_lo;
    logic        w_leave;
    logic [31:0] w_rdata;
    logic [31:0] w_rdata_shr;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_final_result;
    logic [3:0]  w_rf_we;
    logic        w_unused;

    assign w_bd           = bus_q[95];
    assign w_exc_sys      = bus_q[94];
    assign w_eret_flush   = bus_q[93];
    assign w_cp0_wen      = bus_q[92];
    assign w_res_from_cp0 = bus_q[91];
    assign w_cp0_addr     = bus_q[90:83];
    assign w_inst_load    = bus_q[81:75];
    assign w_gr_we        = bus_q[69];
    assign w_dest         = bus_q[68:64];
    assign w_alu_result   = bus_q[63:32];
    assign w_pc           = bus_q[31:0];
    assign w_addr_lo      = w_alu_result[1:0];

    // res_from_mem and the extend-op field are redundant with the one-hot load vector.
    assign w_unused = ^{bus_q[82], bus_q[74:70]};

    assign ms_allowin = !ms_valid_q || ws_allowin;
    assign w_leave    = ms_valid_q && ws_allowin;

    always_comb begin
        ms_valid_d   = ms_valid_q;
        bus_d        = bus_q;
        rdata_held_d = rdata_held_q;
        rdata_buf_d  = rdata_buf_q;

        if (flush) begin
            ms_valid_d = 1'b0;
        end else if (ms_allowin) begin
            ms_valid_d = es_to_ms_valid;
        end

        if (es_to_ms_valid && ms_allowin) begin
            bus_d = es_to_ms_bus;
        end

        // The SRAM only presents read data for one cycle; keep it while the stage is stalled.
        if (flush || w_leave) begin
            rdata_held_d = 1'b0;
        end else if (ms_valid_q && !rdata_held_q) begin
            rdata_held_d = 1'b1;
            rdata_buf_d  = data_sram_rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_valid_q   <= 1'b0;
            rdata_held_q <= 1'b0;
            rdata_buf_q  <= 32'd0;
            bus_q        <= '0;
        end else begin
            ms_valid_q   <= ms_valid_d;
            rdata_held_q <= rdata_held_d;
            rdata_buf_q  <= rdata_buf_d;
            bus_q        <= bus_d;
        end
    end

    assign w_rdata     = rdata_held_q ? rdata_buf_q : data_sram_rdata;
    assign w_rdata_shr = w_rdata >> {w_addr_lo, 3'b000};
    assign w_byte      = w_rdata_shr[7:0];
    assign w_half      = w_addr_lo[1] ? w_rdata[31:16] : w_rdata[15:0];

    always_comb begin
        w_final_result = w_alu_result;
        w_rf_we        = {4{w_gr_we}};

        if (w_inst_load[6]) begin
            w_final_result = w_rdata;
            w_rf_we        = 4'b1111;
        end else if (w_inst_load[5]) begin
            w_final_result = {{24{w_byte[7]}}, w_byte};
            w_rf_we        = 4'b1111;
        end else if (w_inst_load[4]) begin
            w_final_result = {24'd0, w_byte};
            w_rf_we        = 4'b1111;
        end else if (w_inst_load[3]) begin
            w_final_result = {{16{w_half[15]}}, w_half};
            w_rf_we        = 4'b1111;
        end else if (w_inst_load[2]) begin
            w_final_result = {16'd0, w_half};
            w_rf_we        = 4'b1111;
        end else if (w_inst_load[1]) begin
            // 3-a equals ~a for a two-bit offset.
            w_final_result = w_rdata << {~w_addr_lo, 3'b000};
            w_rf_we        = 4'b1111 << ~w_addr_lo;
        end else if (w_inst_load[0]) begin
            w_final_result = w_rdata_shr;
            w_rf_we        = 4'b1111 >> w_addr_lo;
        end

        if ((|w_inst_load) && !w_gr_we) begin
            w_rf_we = 4'b0000;
        end

        // Write-back substitutes the CP0 value; pass the address through untouched.
        if (w_res_from_cp0) begin
            w_final_result = w_alu_result;
        end
    end

    assign ms_to_ws_valid = ms_valid_q;

    assign ms_to_ws_bus = {w_bd, w_exc_sys, w_eret_flush, w_cp0_wen, w_res_from_cp0,
                           w_cp0_addr, w_rf_we, w_dest, w_final_result, w_pc};

    assign stall_ms_bus = {{5{ms_valid_q && w_gr_we}}, w_dest};

    assign forward_ms_bus = {ms_valid_q && w_gr_we && !w_res_from_cp0
                             && !w_inst_load[1] && !w_inst_load[0],
                             w_final_result};

    assign ms_exc_eret_bus = {ms_valid_q && w_exc_sys, ms_valid_q && w_eret_flush};

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed stimulus for mem_stage, checked against a transaction-level model
// plus hand-computed expectations for the key cases.
`default_nettype none

module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        ws_allowin = 1'b0;
    logic        ms_allowin;
    logic        es_to_ms_valid = 1'b0;
    logic [95:0] es_to_ms_bus = '0;
    logic [31:0] data_sram_rdata = '0;
    logic        ms_to_ws_valid;
    logic [85:0] ms_to_ws_bus;
    logic [9:0]  stall_ms_bus;
    logic [32:0] forward_ms_bus;
    logic [1:0]  ms_exc_eret_bus;

    int n_vec = 0;
    int n_err = 0;

    mem_stage dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .ws_allowin      (ws_allowin),
        .ms_allowin      (ms_allowin),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .data_sram_rdata (data_sram_rdata),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ms_to_ws_bus    (ms_to_ws_bus),
        .stall_ms_bus    (stall_ms_bus),
        .forward_ms_bus  (forward_ms_bus),
        .ms_exc_eret_bus (ms_exc_eret_bus)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] LW  = 7'b1000000;
    localparam logic [6:0] LB  = 7'b0100000;
    localparam logic [6:0] LBU = 7'b0010000;
    localparam logic [6:0] LH  = 7'b0001000;
    localparam logic [6:0] LHU = 7'b0000100;
    localparam logic [6:0] LWL = 7'b0000010;
    localparam logic [6:0] LWR = 7'b0000001;
    localparam logic [6:0] NOL = 7'b0000000;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // flags = {bd, exc_sys, eret_flush, cp0_wen, res_from_cp0}
    function automatic logic [95:0] mk(input logic [6:0] ld, input logic grwe, input logic [4:0] dest,
                                       input logic [31:0] addr, input logic [4:0] flags,
                                       input logic [7:0] cp0a);
        return {flags, cp0a, |ld, ld, 5'b10101, grwe, dest, addr, 32'hBFC0_0000 + addr};
    endfunction

    // Expected write-back payload for an instruction whose effective read data is d.
    function automatic logic [85:0] exp_ws(input logic [95:0] b, input logic [31:0] d, output logic fwd);
        logic [6:0]  ld;
        int          a;
        logic [7:0]  by;
        logic [15:0] hw;
        logic [31:0] r;
        logic [3:0]  we;
        ld = b[81:75];
        a  = int'(b[33:32]);
        by = d[8*a +: 8];
        hw = d[16*(a/2) +: 16];
        r  = b[63:32];
        we = {4{b[69]}};
        if (ld != 7'd0) begin
            we = 4'hF;
            case (ld)
                LW:  r = d;
                LB:  r = by[7] ? {24'hFFFFFF, by} : {24'h0, by};
                LBU: r = {24'h0, by};
                LH:  r = hw[15] ? {16'hFFFF, hw} : {16'h0, hw};
                LHU: r = {16'h0, hw};
                LWL: begin r = d << (8*(3-a)); we = 4'hF << (3-a); end
                LWR: begin r = d >> (8*a);     we = 4'hF >> a;     end
                default: ;
            endcase
            if (!b[69]) we = 4'h0;
        end
        if (b[91]) r = b[63:32];
        fwd = b[69] && !b[91] && !ld[1] && !ld[0];
        return {b[95:91], b[90:83], we, b[68:64], r, b[31:0]};
    endfunction

    // Transaction model: what occupies the stage and the read data seen on its first cycle.
    logic        m_valid = 1'b0;
    logic        m_first = 1'b0;
    logic [95:0] m_bus   = '0;
    logic [31:0] m_saved = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid = 1'b0;
            m_first = 1'b0;
            m_bus   = '0;
            m_saved = '0;
        end else begin
            if (m_valid && m_first) m_saved = data_sram_rdata;
            m_first = 1'b0;
            if (es_to_ms_valid && (!m_valid || ws_allowin)) m_bus = es_to_ms_bus;
            if (flush) begin
                m_valid = 1'b0;
            end else if (!m_valid || ws_allowin) begin
                m_valid = es_to_ms_valid;
                m_first = es_to_ms_valid;
            end
        end
    end

    always @(negedge clk) begin
        logic [85:0] e;
        logic        f;
        logic [31:0] d;
        d = (m_valid && !m_first) ? m_saved : data_sram_rdata;
        e = exp_ws(m_bus, d, f);
        chk("allowin", {95'd0, ms_allowin}, {95'd0, !m_valid || ws_allowin});
        chk("valid", {95'd0, ms_to_ws_valid}, {95'd0, m_valid});
        chk("stall_bus", {86'd0, stall_ms_bus}, {86'd0, {5{m_valid && m_bus[69]}}, m_bus[68:64]});
        chk("exc_eret", {94'd0, ms_exc_eret_bus}, {94'd0, m_valid && m_bus[94], m_valid && m_bus[93]});
        if (m_valid) begin
            chk("ws_bus", {10'd0, ms_to_ws_bus}, {10'd0, e});
            chk("fwd_bus", {63'd0, forward_ms_bus}, {63'd0, f, e[63:32]});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction; it enters on the next edge and rd is its first-cycle read data.
    task automatic send(input logic [95:0] b, input logic [31:0] rd);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = b;
        step();
        es_to_ms_valid = 1'b0;
        data_sram_rdata = rd;
    endtask

    logic [95:0] tbl_bus [10];
    logic [31:0] tbl_rd  [10];

    initial begin
        repeat (2) step();
        #2;
        chk("rst_allowin", {95'd0, ms_allowin}, 96'd1);
        chk("rst_valid", {95'd0, ms_to_ws_valid}, 96'd0);
        chk("rst_ws_bus", {10'd0, ms_to_ws_bus}, 96'd0);
        chk("rst_fwd", {63'd0, forward_ms_bus}, 96'd0);
        chk("rst_stall", {86'd0, stall_ms_bus}, 96'd0);
        chk("rst_exc", {94'd0, ms_exc_eret_bus}, 96'd0);
        reset = 1'b0;
        ws_allowin = 1'b1;
        step();

        // Back-to-back lb then lbu at offset 3
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(LB, 1'b1, 5'd7, 32'h0000_1003, 5'b0, 8'h0);
        step();
        es_to_ms_bus    = mk(LBU, 1'b1, 5'd7, 32'h0000_1003, 5'b0, 8'h0);
        data_sram_rdata = 32'h8012_3456;
        #2;
        chk("lb_result", {64'd0, ms_to_ws_bus[63:32]}, 96'hFFFF_FF80);
        chk("lb_rf_we", {92'd0, ms_to_ws_bus[72:69]}, 96'hF);
        step();
        es_to_ms_valid = 1'b0;
        #2;
        chk("lbu_result", {64'd0, ms_to_ws_bus[63:32]}, 96'h0000_0080);
        chk("b2b_not_held", {95'd0, dut.rdata_held_q}, 96'd0);
        step();

        send(mk(LWL, 1'b1, 5'd8, 32'h0000_2001, 5'b0, 8'h0), 32'hAABB_CCDD);
        #2;
        chk("lwl_result", {64'd0, ms_to_ws_bus[63:32]}, 96'hCCDD_0000);
        chk("lwl_rf_we", {92'd0, ms_to_ws_bus[72:69]}, 96'hC);
        send(mk(LWR, 1'b1, 5'd8, 32'h0000_2002, 5'b0, 8'h0), 32'hAABB_CCDD);
        #2;
        chk("lwr_result", {64'd0, ms_to_ws_bus[63:32]}, 96'h0000_AABB);
        chk("lwr_rf_we", {92'd0, ms_to_ws_bus[72:69]}, 96'h3);
        step();

        // Further alignment cases, checked by the model each cycle
        tbl_bus[0] = mk(LH,  1'b1, 5'd9,  32'h0000_3002, 5'b0, 8'h0); tbl_rd[0] = 32'h8001_7FFF;
        tbl_bus[1] = mk(LHU, 1'b1, 5'd9,  32'h0000_3003, 5'b0, 8'h0); tbl_rd[1] = 32'h8001_7FFF;
        tbl_bus[2] = mk(LH,  1'b1, 5'd9,  32'h0000_3000, 5'b0, 8'h0); tbl_rd[2] = 32'h1234_F00D;
        tbl_bus[3] = mk(LW,  1'b1, 5'd10, 32'h0000_3004, 5'b0, 8'h0); tbl_rd[3] = 32'hCAFE_F00D;
        tbl_bus[4] = mk(LWL, 1'b1, 5'd11, 32'h0000_3000, 5'b0, 8'h0); tbl_rd[4] = 32'h1122_3344;
        tbl_bus[5] = mk(LWL, 1'b1, 5'd11, 32'h0000_3003, 5'b0, 8'h0); tbl_rd[5] = 32'h1122_3344;
        tbl_bus[6] = mk(LWR, 1'b1, 5'd11, 32'h0000_3000, 5'b0, 8'h0); tbl_rd[6] = 32'h1122_3344;
        tbl_bus[7] = mk(LWR, 1'b1, 5'd11, 32'h0000_3003, 5'b0, 8'h0); tbl_rd[7] = 32'h1122_3344;
        tbl_bus[8] = mk(LB,  1'b0, 5'd12, 32'h0000_3001, 5'b0, 8'h0); tbl_rd[8] = 32'h0000_9900;
        tbl_bus[9] = mk(NOL, 1'b0, 5'd13, 32'h0000_ABCD, 5'b0, 8'h0); tbl_rd[9] = 32'h5555_5555;
        es_to_ms_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            es_to_ms_bus = tbl_bus[i];
            step();
            data_sram_rdata = tbl_rd[i];
        end
        es_to_ms_valid = 1'b0;
        #2;
        chk("nonload_nowe", {92'd0, ms_to_ws_bus[72:69]}, 96'h0);
        step();

        // Stall with read data changing after the first cycle
        ws_allowin = 1'b0;
        send(mk(LW, 1'b1, 5'd14, 32'h0000_4000, 5'b0, 8'h0), 32'h1122_3344);
        step();
        data_sram_rdata = 32'hDEAD_BEEF;
        step();
        step();
        ws_allowin = 1'b1;
        #2;
        chk("stall_result", {64'd0, ms_to_ws_bus[63:32]}, 96'h1122_3344);
        chk("stall_held", {95'd0, dut.rdata_held_q}, 96'd1);
        step();
        #2;
        chk("depart_held", {95'd0, dut.rdata_held_q}, 96'd0);
        chk("depart_valid", {95'd0, ms_to_ws_valid}, 96'd0);

        // Flush while a load with a syscall is held
        ws_allowin = 1'b0;
        send(mk(LW, 1'b1, 5'd15, 32'h0000_5000, 5'b01000, 8'h0), 32'h0BAD_F00D);
        step();
        #2;
        chk("exc_before_flush", {94'd0, ms_exc_eret_bus}, 96'd2);
        flush = 1'b1;
        step();
        flush = 1'b0;
        #2;
        chk("flush_valid", {95'd0, ms_to_ws_valid}, 96'd0);
        chk("flush_held", {95'd0, dut.rdata_held_q}, 96'd0);
        chk("flush_exc", {94'd0, ms_exc_eret_bus}, 96'd0);
        ws_allowin = 1'b1;
        step();

        // Forwarding
        send(mk(NOL, 1'b1, 5'd5, 32'h1234_5678, 5'b0, 8'h0), 32'h0);
        #2;
        chk("fwd_add", {63'd0, forward_ms_bus}, {63'd0, 1'b1, 32'h1234_5678});
        chk("stall_add", {86'd0, stall_ms_bus}, {86'd0, 10'b11111_00101});
        send(mk(LWL, 1'b1, 5'd5, 32'h0000_6001, 5'b0, 8'h0), 32'hAABB_CCDD);
        #2;
        chk("fwd_lwl", {95'd0, forward_ms_bus[32]}, 96'd0);
        chk("stall_lwl", {86'd0, stall_ms_bus}, {86'd0, 10'b11111_00101});
        send(mk(NOL, 1'b1, 5'd5, 32'h0000_0070, 5'b00001, 8'h60), 32'hFFFF_FFFF);
        #2;
        chk("fwd_mfc0", {95'd0, forward_ms_bus[32]}, 96'd0);
        chk("stall_mfc0", {86'd0, stall_ms_bus}, {86'd0, 10'b11111_00101});
        chk("mfc0_result", {64'd0, ms_to_ws_bus[63:32]}, 96'h0000_0070);
        step();

        // Asynchronous reset between edges during a stalled load
        ws_allowin = 1'b0;
        send(mk(LW, 1'b1, 5'd6, 32'h0000_7000, 5'b0, 8'h0), 32'h7777_7777);
        #1;
        reset = 1'b1;
        #1;
        chk("areset_valid", {95'd0, ms_to_ws_valid}, 96'd0);
        chk("areset_allowin", {95'd0, ms_allowin}, 96'd1);
        step();
        #2;
        reset = 1'b0;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
